// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
//   uart_arb_state_e : transmitter FSM states (PARITY only exists when
//                      UART_TX_ARB_PARITY_EN is defined)
//   uart_arb_req_t   : one requester's valid/lock/data bundle
//   DATA_BITS        : data bits per frame
//   even_parity()    : XOR of the data bits
// Configuration macro: UART_TX_ARB_PARITY_EN
package uart_arb_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_ARB_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 lock;
        logic [DATA_BITS-1:0] data;
    } uart_arb_req_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_baud.sv
// Baud timing generator.
//   clock, reset : clock, asynchronous active-high reset
//   enable       : count while high; dropping it clears the counter so the
//                  next rising enable restarts a full bit period
//   bit_tick     : one-cycle pulse on the last cycle of each bit period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_tick = enable && (cnt_q == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (!enable || bit_tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter with lock-aware round-robin arbitration.
//   clock, reset          : clock, asynchronous active-high reset
//   reqN_valid/data/lock  : byte pending, byte value, keep grant for next byte
//   reqN_ready            : combinational accept strobe (IDLE only)
//   uart_tx               : serial line, idle high, 8N1 (8E1 with parity)
//   busy                  : high whenever a frame is in flight
//   grant_id              : requester owning the current / last frame
// Configuration macro: UART_TX_ARB_PARITY_EN adds an even parity bit.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic       grant_id
);

    uart_arb_req_t [1:0] req;
    assign req[0] = '{valid: req0_valid, lock: req0_lock, data: req0_data};
    assign req[1] = '{valid: req1_valid, lock: req1_lock, data: req1_data};

    uart_arb_state_e      state_q, state_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 tx_q, tx_d;
    logic                 gid_q, gid_d;
    logic                 last_q, last_d;   // arbitration history, separate from grant_id reset value
    logic                 gnt_vld, gnt_sel, accept, bit_tick;
    logic [BIT_W-1:0]     bit_nxt;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock    (clock),
        .reset    (reset),
        .enable   (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    // Lock only sticks while its owner is still valid; otherwise plain round-robin.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (req[last_q].valid && req[last_q].lock) begin
            gnt_vld = 1'b1;
            gnt_sel = last_q;
        end else if (req[0].valid && req[1].valid) begin
            gnt_vld = 1'b1;
            gnt_sel = ~last_q;
        end else if (req[0].valid) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b0;
        end else if (req[1].valid) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
        end
    end

    // Gating with reset keeps ready low while reset is held, not just after an edge.
    assign accept     = (state_q == IDLE) && gnt_vld && !reset;
    assign req0_ready = accept && !gnt_sel;
    assign req1_ready = accept &&  gnt_sel;

    assign bit_nxt = bit_q + BIT_W'(1);

    // tx is computed for the next state so the line is registered and glitch-free.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                bit_d = '0;
                if (accept) begin
                    data_d  = req[gnt_sel].data;
                    gid_d   = gnt_sel;
                    last_d  = gnt_sel;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_ARB_PARITY_EN
                        state_d = PARITY;
                        tx_d    = even_parity(data_q);
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1, single clock for all state.
REQ-003 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, requester has a byte pending.
REQ-005 SHALL have ports req0_data/req1_data, input, 8 each, byte to send; stable while valid.
REQ-006 SHALL have ports req0_lock/req1_lock, input, 1 each, holds the grant across consecutive bytes.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each, byte accepted on a valid&ready edge.
REQ-008 SHALL have port uart_tx, output, 1, serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is in flight.
REQ-010 SHALL have port grant_id, output, 1, requester owning the current or last frame.

Function
REQ-011 SHALL use the FSM states IDLE, START, DATA, [PARITY], STOP.
REQ-012 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, and only while that requester is valid.
REQ-013 SHALL decide the IDLE grant as follows, in priority order:
- if last grant holder has lock high and valid high, it keeps the grant;
- else if both requesters are valid, grant goes to the one not granted last (round-robin);
- else the single valid requester is granted;
- else no grant.
REQ-014 SHALL latch the data and grant_id on acceptance, then enter START on the next edge.
REQ-015 SHALL drive uart_tx=0 for exactly CLKS_PER_BIT cycles in START.
REQ-016 SHALL send the 8 data bits LSB first in DATA, each held for CLKS_PER_BIT cycles.
REQ-017 SHALL drive uart_tx=1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-018 SHALL have a frame duration of 10*CLKS_PER_BIT cycles (11* with parity), from the cycle after acceptance.
REQ-019 SHALL insert exactly one IDLE cycle between back-to-back frames; maximum throughput is 1 byte per (frame+1) cycles.
REQ-020 SHALL set busy=1 in every state except IDLE.
REQ-021 SHALL leave grant_id holding its last value in IDLE.
REQ-022 SHALL use a bit counter and a baud counter that are CLKS_PER_BIT-width-safe (clog2), and both SHALL wrap to 0 at each bit boundary.
REQ-023 SHALL ignore lock when its owner drops valid; the other requester is then granted.
REQ-024 SHALL ignore changes on valid or data during a frame, with no effect on the frame.

Reset
REQ-025 SHALL on reset assertion force the following outputs immediately, asynchronously and regardless of clock:
- uart_tx=1, busy=0, req0_ready=0, req1_ready=0, grant_id=0;
- state=IDLE, counters=0;
- last-grant register=1, so requester 0 wins first.
REQ-026 SHALL abort a frame when reset arrives mid-frame; on release no partial frame resumes and the aborted byte is lost.
REQ-027 SHALL allow acceptance no earlier than the first rising edge after reset deassertion.

Configuration
REQ-028 SHALL, with UART_TX_ARB_PARITY_EN defined, insert a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-029 SHALL, without UART_TX_ARB_PARITY_EN, omit the PARITY state entirely and make frames 10 bits.

Structure
REQ-030 SHALL place the state enum typedef (uart_arb_state_e), the DATA_BITS=8 constant and the parity function in shared package uart_arb_pkg.
REQ-031 SHALL implement baud timing in sub-module uart_baud_gen, which emits a one-cycle bit_tick every CLKS_PER_BIT cycles while enabled and restarts on enable rising.

Verification
REQ-032 SHALL cover: CLKS_PER_BIT=4, req0 sends 0xA5 -> uart_tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; req0_ready high for 1 cycle; busy high 40 cycles.
REQ-033 SHALL cover: both requesters continuously valid, no lock -> grants alternate 0,1,0,1 with one IDLE cycle between frames.
REQ-034 SHALL cover: req1 valid with lock high for 3 bytes while req0 is valid -> 3 consecutive req1 frames, then req0 is granted.
REQ-035 SHALL cover: reset asserted mid-DATA at bit 3 -> uart_tx=1 and busy=0 within the same cycle, with no clock edge needed; after release, next frame starts cleanly.
REQ-036 SHALL cover: UART_TX_ARB_PARITY_EN defined, byte 0x07 -> parity bit 1, frame 11 bits (44 cycles at CLKS_PER_BIT=4).
REQ-037 SHALL cover: valid dropped and data changed mid-frame -> serialized bits match the accepted byte.
